hazard_ctrl: RTL and testbench

Pipeline hazard controller for the five-stage RV32I core (IF, ID, EX, MEM, WB). It tracks destination registers of in-flight instructions and generates ALU operand forwarding selects for the EX stage. It also produces load-use stalls with bubble insertion, and flushes on taken branches, JAL and JALR resolved by the ALU. It sits beside the ID/EX pipeline registers and drives the operand muxes ahead of the ALU's `src1`/`src2` inputs.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/hazard_match.sv | 16 +
 rtl/hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings and stage tracking record for hazard_ctrl
package hazard_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             we;
        logic             load;
    } stage_t;

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - producer/consumer register match for one stage and one source
module hazard_match
    import hazard_pkg::*;
(
    input  stage_t           stg,
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    input  logic             load_only,
    output logic             hit
);

    // x0 is hardwired zero, so a write to it is never a real producer
    assign hit = stg.valid && stg.we && (stg.rd != '0) && (stg.rd == src) && use_src
                 && (!load_only || stg.load);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RV32I five-stage hazard controller; HAZARD_FORWARD_EN enables EX operand forwarding
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int XLEN_REGS = REG_W
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 id_valid,
    input  logic [XLEN_REGS-1:0] id_rs1,
    input  logic [XLEN_REGS-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic [XLEN_REGS-1:0] id_rd,
    input  logic                 id_reg_write,
    input  logic                 id_is_load,
    input  logic                 ex_redirect,
    output logic                 stall,
    output logic                 bubble,
    output logic                 flush,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          flush_cnt
);

    stage_t      ex_q, ex_d, mem_q, mem_d;
    logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic        stall_w, flush_w;
    logic        id1_ex_hit, id2_ex_hit;

`ifdef HAZARD_FORWARD_EN
    localparam logic ID_LOAD_ONLY = 1'b1;
    stage_t               wb_q, wb_d;
    logic [XLEN_REGS-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d;
    logic                 ex_use1_q, ex_use1_d, ex_use2_q, ex_use2_d;
    logic                 a_mem_hit, a_wb_hit, b_mem_hit, b_wb_hit;
`else
    localparam logic ID_LOAD_ONLY = 1'b0;
    logic                 id1_mem_hit, id2_mem_hit;
`endif

    hazard_match u_id1_ex (.stg(ex_q), .src(id_rs1), .use_src(id_valid && id_use_rs1),
                           .load_only(ID_LOAD_ONLY), .hit(id1_ex_hit));
    hazard_match u_id2_ex (.stg(ex_q), .src(id_rs2), .use_src(id_valid && id_use_rs2),
                           .load_only(ID_LOAD_ONLY), .hit(id2_ex_hit));

    assign flush_w = ex_redirect;

`ifdef HAZARD_FORWARD_EN
    hazard_match u_a_mem (.stg(mem_q), .src(ex_rs1_q), .use_src(ex_q.valid && ex_use1_q),
                          .load_only(1'b0), .hit(a_mem_hit));
    hazard_match u_a_wb  (.stg(wb_q),  .src(ex_rs1_q), .use_src(ex_q.valid && ex_use1_q),
                          .load_only(1'b0), .hit(a_wb_hit));
    hazard_match u_b_mem (.stg(mem_q), .src(ex_rs2_q), .use_src(ex_q.valid && ex_use2_q),
                          .load_only(1'b0), .hit(b_mem_hit));
    hazard_match u_b_wb  (.stg(wb_q),  .src(ex_rs2_q), .use_src(ex_q.valid && ex_use2_q),
                          .load_only(1'b0), .hit(b_wb_hit));

    // only a load in EX can't be forwarded in time; a redirect kills the consumer anyway
    assign stall_w = (id1_ex_hit || id2_ex_hit) && !flush_w;

    always_comb begin
        wb_d      = mem_q;
        ex_rs1_d  = id_rs1;
        ex_rs2_d  = id_rs2;
        ex_use1_d = id_use_rs1;
        ex_use2_d = id_use_rs2;
        fwd_a     = FWD_RF;
        fwd_b     = FWD_RF;
        if (a_mem_hit) begin
            fwd_a = FWD_MEM;
        end else if (a_wb_hit) begin
            fwd_a = FWD_WB;
        end
        if (b_mem_hit) begin
            fwd_b = FWD_MEM;
        end else if (b_wb_hit) begin
            fwd_b = FWD_WB;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wb_q      <= '0;
            ex_rs1_q  <= '0;
            ex_rs2_q  <= '0;
            ex_use1_q <= 1'b0;
            ex_use2_q <= 1'b0;
        end else begin
            wb_q      <= wb_d;
            ex_rs1_q  <= ex_rs1_d;
            ex_rs2_q  <= ex_rs2_d;
            ex_use1_q <= ex_use1_d;
            ex_use2_q <= ex_use2_d;
        end
    end
`else
    hazard_match u_id1_mem (.stg(mem_q), .src(id_rs1), .use_src(id_valid && id_use_rs1),
                            .load_only(1'b0), .hit(id1_mem_hit));
    hazard_match u_id2_mem (.stg(mem_q), .src(id_rs2), .use_src(id_valid && id_use_rs2),
                            .load_only(1'b0), .hit(id2_mem_hit));

    // without bypass paths the consumer waits until its producer reaches the write-through WB
    assign stall_w = (id1_ex_hit || id2_ex_hit || id1_mem_hit || id2_mem_hit) && !flush_w;
    assign fwd_a   = FWD_RF;
    assign fwd_b   = FWD_RF;
`endif

    always_comb begin
        ex_d        = '0;
        ex_d.valid  = id_valid && !stall_w && !flush_w;
        ex_d.rd     = id_rd;
        ex_d.we     = id_reg_write;
        ex_d.load   = id_is_load;
        mem_d       = ex_q;
        stall_cnt_d = stall_cnt_q + {31'd0, stall_w};
        flush_cnt_d = flush_cnt_q + {31'd0, flush_w};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ex_q        <= '0;
            mem_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall     = stall_w;
    assign bubble    = stall_w;
    assign flush     = flush_w;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - table-driven scoreboard bench for hazard_ctrl (both HAZARD_FORWARD_EN builds)
module tb_hazard_ctrl;

`ifdef HAZARD_FORWARD_EN
    localparam int MODE = 1;
`else
    localparam int MODE = 2;
`endif

    logic        CLK, RST;
    logic        id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_is_load, ex_redirect;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        stall, bubble, flush;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cnt, flush_cnt;

    hazard_ctrl dut (
        .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
        .stall(stall), .bubble(bubble), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct {
        logic       v;
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, we, ld, rx;
        logic       st, fl;
        logic [1:0] fa, fb;
        int         cfg;
    } row_t;

    typedef struct {
        int          idx;
        logic [6:0]  outs;
        logic [31:0] sc, fc;
    } exp_t;

    row_t        vec[$];
    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          row_no   = 0;
    logic [31:0] exp_sc   = 0;
    logic [31:0] exp_fc   = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    function automatic row_t mk(input int v, input int rs1, input int u1, input int rs2,
                                input int u2, input int rd, input int we, input int ld,
                                input int rx, input int st, input int fl, input int fa,
                                input int fb, input int cfg);
        row_t r;
        r.v = 1'(v); r.rs1 = 5'(rs1); r.u1 = 1'(u1); r.rs2 = 5'(rs2); r.u2 = 1'(u2);
        r.rd = 5'(rd); r.we = 1'(we); r.ld = 1'(ld); r.rx = 1'(rx);
        r.st = 1'(st); r.fl = 1'(fl); r.fa = 2'(fa); r.fb = 2'(fb); r.cfg = cfg;
        return r;
    endfunction

    function automatic row_t nop(input int fa, input int fb, input int cfg);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fa, fb, cfg);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic apply(input row_t r);
        exp_t e;
        id_valid = r.v; id_rs1 = r.rs1; id_rs2 = r.rs2; id_use_rs1 = r.u1; id_use_rs2 = r.u2;
        id_rd = r.rd; id_reg_write = r.we; id_is_load = r.ld; ex_redirect = r.rx;
        e.idx = row_no; e.outs = {r.st, r.st, r.fl, r.fa, r.fb}; e.sc = exp_sc; e.fc = exp_fc;
        sb.push_back(e);
        @(negedge CLK);
        e = sb.pop_front();
        check($sformatf("row%0d_stall_bubble_flush_fwda_fwdb", e.idx),
              {25'd0, stall, bubble, flush, fwd_a, fwd_b}, {25'd0, e.outs});
        check($sformatf("row%0d_stall_cnt", e.idx), stall_cnt, e.sc);
        check($sformatf("row%0d_flush_cnt", e.idx), flush_cnt, e.fc);
        exp_sc = exp_sc + 32'(r.st);
        exp_fc = exp_fc + 32'(r.fl);
        row_no++;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // v rs1 u1 rs2 u2 rd we ld rx | st fl fa fb | cfg (0 both, 1 forward, 2 no-forward)
        vec.push_back(nop(0, 0, 0));
        // add x1,x2,x3 ; add x4,x1,x5
        vec.push_back(mk(1, 2, 1, 3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vec.push_back(mk(1, 1, 1, 5, 1, 4, 1, 0, 0, 0, 0, 0, 0, 1));
        vec.push_back(mk(1, 1, 1, 5, 1, 4, 1, 0, 0, 1, 0, 0, 0, 2));
        vec.push_back(mk(1, 1, 1, 5, 1, 4, 1, 0, 0, 1, 0, 0, 0, 2));
        vec.push_back(mk(1, 1, 1, 5, 1, 4, 1, 0, 0, 0, 0, 0, 0, 2));
        vec.push_back(nop(1, 0, 1));
        vec.push_back(nop(0, 0, 2));
        for (int i = 0; i < 3; i++) vec.push_back(nop(0, 0, 0));
        // add x1 ; nop ; sub x6,x7,x1
        vec.push_back(mk(1, 2, 1, 3, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vec.push_back(nop(0, 0, 0));
        vec.push_back(mk(1, 7, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 1));
        vec.push_back(mk(1, 7, 1, 1, 1, 6, 1, 0, 0, 1, 0, 0, 0, 2));
        vec.push_back(mk(1, 7, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 2));
        vec.push_back(nop(0, 2, 1));
        vec.push_back(nop(0, 0, 2));
        // addi x1,x2 ; addi x1,x3 ; add x8,x1,x9 -> MEM beats WB
        vec.push_back(mk(1, 2, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vec.push_back(mk(1, 3, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vec.push_back(mk(1, 1, 1, 9, 1, 8, 1, 0, 0, 0, 0, 0, 0, 1));
        vec.push_back(mk(1, 1, 1, 9, 1, 8, 1, 0, 0, 1, 0, 0, 0, 2));
        vec.push_back(mk(1, 1, 1, 9, 1, 8, 1, 0, 0, 1, 0, 0, 0, 2));
        vec.push_back(mk(1, 1, 1, 9, 1, 8, 1, 0, 0, 0, 0, 0, 0, 2));
        vec.push_back(nop(1, 0, 1));
        vec.push_back(nop(0, 0, 2));
        for (int i = 0; i < 2; i++) vec.push_back(nop(0, 0, 0));
        // lw x5,0(x2) ; add x6,x5,x5
        vec.push_back(mk(1, 2, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0));
        vec.push_back(mk(1, 5, 1, 5, 1, 6, 1, 0, 0, 1, 0, 0, 0, 0));
        vec.push_back(mk(1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 0, 1));
        vec.push_back(mk(1, 5, 1, 5, 1, 6, 1, 0, 0, 1, 0, 0, 0, 2));
        vec.push_back(mk(1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 0, 2));
        vec.push_back(nop(2, 2, 1));
        vec.push_back(nop(0, 0, 2));
        for (int i = 0; i < 2; i++) vec.push_back(nop(0, 0, 0));
        // addi x0,x1,1 ; add x2,x0,x0
        vec.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        vec.push_back(mk(1, 0, 1, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0));
        vec.push_back(nop(0, 0, 0));
        vec.push_back(nop(0, 0, 0));
        // lw x5 in EX, dependent in ID, redirect the same cycle
        vec.push_back(mk(1, 2, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0));
        vec.push_back(mk(1, 5, 1, 5, 1, 6, 1, 0, 1, 0, 1, 0, 0, 0));
        vec.push_back(mk(1, 6, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0));
        vec.push_back(nop(0, 0, 0));
        // jal x1 redirects but its rd stays tracked
        vec.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vec.push_back(mk(1, 3, 1, 4, 1, 10, 1, 0, 1, 0, 1, 0, 0, 0));
        vec.push_back(mk(1, 1, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 1));
        vec.push_back(mk(1, 1, 1, 0, 0, 9, 1, 0, 0, 1, 0, 0, 0, 2));
        vec.push_back(mk(1, 1, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 2));
        vec.push_back(nop(2, 0, 1));
        vec.push_back(nop(0, 0, 2));
        // producers x1,x2,x3 fill EX/MEM/WB ahead of the reset sequence
        for (int i = 1; i <= 3; i++) vec.push_back(mk(1, 0, 0, 0, 0, i, 1, 0, 0, 0, 0, 0, 0, 0));

        RST = 1'b1; id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        id_rd = 0; id_reg_write = 0; id_is_load = 0; ex_redirect = 0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        foreach (vec[i]) begin
            if (vec[i].cfg == 0 || vec[i].cfg == MODE) apply(vec[i]);
        end

        // mid-run reset with a dependent of x1/x2 waiting in ID
        RST = 1'b1;
        id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_use_rs1 = 1; id_use_rs2 = 1;
        id_rd = 4; id_reg_write = 1; id_is_load = 0; ex_redirect = 0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_sc = 0;
        exp_fc = 0;
        apply(mk(1, 1, 1, 2, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0));
        apply(nop(0, 0, 0));
        apply(nop(0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
